// File: rtl/shifter_pkg.sv
// Shared types and helpers for the pipelined barrel shifter.
// Operation encoding and the mapping of mux levels onto register stages.
package shifter_pkg;

  typedef enum logic [1:0] {
    SH_SLL = 2'b00,
    SH_SRL = 2'b01,
    SH_SRA = 2'b10,
    SH_ROR = 2'b11
  } shift_op_e;

  function automatic int levels_per_stage(input int shamt_w, input int stages);
    return (shamt_w + stages - 1) / stages;
  endfunction

  // Every stage takes a full share; the last one takes whatever is left (possibly none).
  function automatic int stage_levels(input int shamt_w, input int stages, input int k);
    int per;
    int rem;
    per = levels_per_stage(shamt_w, stages);
    rem = shamt_w - k * per;
    if (rem < 0) rem = 0;
    if (rem > per) rem = per;
    return rem;
  endfunction

endpackage

// File: rtl/barrel_shift_stage.sv
// One pipeline slice: a contiguous range of log-shifter mux levels followed by
// a register holding partial data, the shift amount, op and the SRA fill bit.
module barrel_shift_stage
  import shifter_pkg::*;
#(
  parameter  int WIDTH       = 64,
  parameter  int FIRST_LEVEL = 0,
  parameter  int NUM_LEVELS  = 1,
  localparam int SHAMT_W     = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               up_valid,
  output logic               up_ready,
  input  logic [WIDTH-1:0]   up_data,
  input  logic [SHAMT_W-1:0] up_shamt,
  input  shift_op_e          up_op,
  input  logic               up_fill,
  output logic               down_valid,
  input  logic               down_ready,
  output logic [WIDTH-1:0]   down_data,
  output logic [SHAMT_W-1:0] down_shamt,
  output shift_op_e          down_op,
  output logic               down_fill
);

  logic [WIDTH-1:0] lvl [0:NUM_LEVELS];

  assign lvl[0] = up_data;

  for (genvar j = 0; j < NUM_LEVELS; j++) begin : g_level
    localparam int L = FIRST_LEVEL + j;
    localparam int S = 1 << L;
    logic [WIDTH-1:0] shifted;

    // SRA uses the fill bit captured at acceptance, never the current MSB.
    always_comb begin
      shifted = lvl[j];
      case (up_op)
        SH_SLL:  shifted = lvl[j] << S;
        SH_SRL:  shifted = lvl[j] >> S;
        SH_SRA:  shifted = (lvl[j] >> S) | (up_fill ? ~({WIDTH{1'b1}} >> S) : '0);
        default: shifted = (lvl[j] >> S) | (lvl[j] << (WIDTH - S));
      endcase
    end

    assign lvl[j+1] = up_shamt[L] ? shifted : lvl[j];
  end

  logic               valid_q;
  logic [WIDTH-1:0]   data_q;
  logic [SHAMT_W-1:0] shamt_q;
  shift_op_e          op_q;
  logic               fill_q;

  assign up_ready = !valid_q || down_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      shamt_q <= '0;
      op_q    <= SH_SLL;
      fill_q  <= 1'b0;
    end else if (up_ready) begin
      valid_q <= up_valid;
      if (up_valid) begin
        data_q  <= lvl[NUM_LEVELS];
        shamt_q <= up_shamt;
        op_q    <= up_op;
        fill_q  <= up_fill;
      end
    end
  end

  assign down_valid = valid_q;
  assign down_data  = data_q;
  assign down_shamt = shamt_q;
  assign down_op    = op_q;
  assign down_fill  = fill_q;

endmodule

// File: rtl/pipelined_barrel_shifter.sv
// Parametrised multi-mode barrel shifter (SLL/SRL/SRA/ROR) split over STAGES
// register slices with valid/ready on both sides.
module pipelined_barrel_shifter
  import shifter_pkg::*;
#(
  parameter  int WIDTH   = 64,
  parameter  int STAGES  = 2,
  localparam int SHAMT_W = $clog2(WIDTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_data,
  input  logic [SHAMT_W-1:0] in_shamt,
  input  logic [1:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_data
);

  localparam int  PER       = levels_per_stage(SHAMT_W, STAGES);
  localparam bit  PARAMS_OK = (WIDTH >= 8) && ((WIDTH & (WIDTH - 1)) == 0) &&
                              (STAGES >= 1) && (STAGES <= SHAMT_W);

  // Index k is the input side of stage k; index STAGES is the block output.
  logic               valid_a [0:STAGES];
  logic               ready_a [0:STAGES];
  logic [WIDTH-1:0]   data_a  [0:STAGES];
  logic [SHAMT_W-1:0] shamt_a [0:STAGES];
  shift_op_e          op_a    [0:STAGES];
  logic               fill_a  [0:STAGES];

  assign valid_a[0]      = in_valid;
  assign data_a[0]       = in_data;
  assign shamt_a[0]      = in_shamt;
  assign op_a[0]         = shift_op_e'(in_op);
  assign fill_a[0]       = in_data[WIDTH-1];
  assign ready_a[STAGES] = out_ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    barrel_shift_stage #(
      .WIDTH       (WIDTH),
      .FIRST_LEVEL (k * PER),
      .NUM_LEVELS  (stage_levels(SHAMT_W, STAGES, k))
    ) u_stage (
      .clk        (clk),
      .rst        (rst),
      .up_valid   (valid_a[k]),
      .up_ready   (ready_a[k]),
      .up_data    (data_a[k]),
      .up_shamt   (shamt_a[k]),
      .up_op      (op_a[k]),
      .up_fill    (fill_a[k]),
      .down_valid (valid_a[k+1]),
      .down_ready (ready_a[k+1]),
      .down_data  (data_a[k+1]),
      .down_shamt (shamt_a[k+1]),
      .down_op    (op_a[k+1]),
      .down_fill  (fill_a[k+1])
    );
  end

  assign in_ready  = ready_a[0];
  assign out_valid = valid_a[STAGES];
  assign out_data  = data_a[STAGES];

  // Side-band fields are dead once the last stage has applied its levels.
  logic unused_tail;
  assign unused_tail = ^{shamt_a[STAGES], op_a[STAGES], fill_a[STAGES]};

  param_legal_a : assert property (@(posedge clk) PARAMS_OK)
    else $error("pipelined_barrel_shifter: illegal WIDTH/STAGES");

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// Directed self-checking bench for pipelined_barrel_shifter (WIDTH=64, STAGES=2).
module tb_pipelined_barrel_shifter;

  localparam int WIDTH   = 64;
  localparam int STAGES  = 2;
  localparam int SHAMT_W = 6;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;
  localparam logic [1:0] OP_ROR = 2'b11;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [SHAMT_W-1:0] in_shamt;
  logic [1:0]         in_op;
  logic               out_valid;
  logic               out_ready;
  logic [WIDTH-1:0]   out_data;

  int checks   = 0;
  int failures = 0;

  pipelined_barrel_shifter #(.WIDTH(WIDTH), .STAGES(STAGES)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_shamt  (in_shamt),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic [SHAMT_W-1:0] s,
                       input logic [1:0] op);
    in_valid = v;
    in_data  = d;
    in_shamt = s;
    in_op    = op;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, '0, '0, OP_SLL);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_out_valid got=%b want=0", out_valid);
    end
    checks++;
    if (out_data !== 64'h0) begin
      failures++;
      $display("FAIL reset_out_data got=%h want=0", out_data);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got=%b want=1", in_ready);
    end
  endtask

  // Single op with an idle pipeline: result must appear exactly STAGES edges after accept.
  task automatic test_single(input string name, input logic [WIDTH-1:0] d,
                             input logic [SHAMT_W-1:0] s, input logic [1:0] op,
                             input logic [WIDTH-1:0] exp);
    drive(1'b1, d, s, op);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL %s_in_ready got=%b want=1", name, in_ready);
    end
    tick();
    drive(1'b0, '0, '0, OP_SLL);
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_early_valid got=%b want=0", name, out_valid);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp) begin
      failures++;
      $display("FAIL %s got valid=%b data=%h want valid=1 data=%h", name, out_valid, out_data, exp);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL %s_dup got=%b want=0", name, out_valid);
    end
  endtask

  task automatic test_modes();
    test_single("sra4",      64'h8000_0000_0000_0000, 6'd4,  OP_SRA, 64'hF800_0000_0000_0000);
    test_single("sra63",     64'h8000_0000_0000_0000, 6'd63, OP_SRA, 64'hFFFF_FFFF_FFFF_FFFF);
    test_single("sra0",      64'h8000_0000_0000_0000, 6'd0,  OP_SRA, 64'h8000_0000_0000_0000);
    test_single("sra_pos",   64'h7000_0000_0000_0000, 6'd4,  OP_SRA, 64'h0700_0000_0000_0000);
    test_single("sra_split", 64'h8000_0000_0000_0000, 6'd40, OP_SRA, 64'hFFFF_FFFF_FF80_0000);
    test_single("srl13",     64'h8000_0000_0000_0000, 6'd13, OP_SRL, 64'h0004_0000_0000_0000);
    test_single("sll4",      64'hA0A0_A0A0_A0A0_A0A0, 6'd4,  OP_SLL, 64'h0A0A_0A0A_0A0A_0A00);
    test_single("sll63",     64'h0000_0000_0000_0003, 6'd63, OP_SLL, 64'h8000_0000_0000_0000);
    test_single("ror1",      64'h0000_0000_0000_0001, 6'd1,  OP_ROR, 64'h8000_0000_0000_0000);
    test_single("ror32",     64'h0123_4567_89AB_CDEF, 6'd32, OP_ROR, 64'h89AB_CDEF_0123_4567);
    test_single("ror0",      64'h0123_4567_89AB_CDEF, 6'd0,  OP_ROR, 64'h0123_4567_89AB_CDEF);
    test_single("ror36",     64'h0123_4567_89AB_CDEF, 6'd36, OP_ROR, 64'h789A_BCDE_F012_3456);
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0]   d   [4];
    logic [SHAMT_W-1:0] s   [4];
    logic [1:0]         op  [4];
    logic [WIDTH-1:0]   exp [4];
    d[0] = 64'hF000_0000_0000_0000; s[0] = 6'd8;  op[0] = OP_SRA; exp[0] = 64'hFFF0_0000_0000_0000;
    d[1] = 64'hFFFF_FFFF_FFFF_FFFF; s[1] = 6'd60; op[1] = OP_SRL; exp[1] = 64'h0000_0000_0000_000F;
    d[2] = 64'h0000_0000_0000_0001; s[2] = 6'd36; op[2] = OP_SLL; exp[2] = 64'h0000_0010_0000_0000;
    d[3] = 64'h0000_0000_0000_00FF; s[3] = 6'd4;  op[3] = OP_ROR; exp[3] = 64'hF000_0000_0000_000F;
    for (int c = 0; c < 6; c++) begin
      if (c < 4) drive(1'b1, d[c], s[c], op[c]);
      else drive(1'b0, '0, '0, OP_SLL);
      if (c < 4) begin
        checks++;
        if (in_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_in_ready[%0d] got=%b want=1", c, in_ready);
        end
      end
      tick();
      if (c >= 1 && c <= 4) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== exp[c-1]) begin
          failures++;
          $display("FAIL b2b_result[%0d] got valid=%b data=%h want valid=1 data=%h",
                   c - 1, out_valid, out_data, exp[c-1]);
        end
      end else begin
        checks++;
        if (out_valid !== 1'b0) begin
          failures++;
          $display("FAIL b2b_idle[%0d] got=%b want=0", c, out_valid);
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    logic [WIDTH-1:0] exp_c;
    exp_a = 64'h0000_0000_0000_0002;
    exp_b = 64'h0000_0000_0000_0001;
    exp_c = 64'hC000_0000_0000_0000;
    out_ready = 1'b0;
    drive(1'b1, 64'h1, 6'd1, OP_SLL);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_a got=%b want=1", in_ready);
    end
    tick();
    drive(1'b1, 64'h100, 6'd8, OP_SRL);
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_ready_b got=%b want=1", in_ready);
    end
    tick();
    drive(1'b1, 64'h8000_0000_0000_0000, 6'd1, OP_SRA);
    for (int c = 0; c < 3; c++) begin
      checks++;
      if (in_ready !== 1'b0) begin
        failures++;
        $display("FAIL bp_full_ready[%0d] got=%b want=0", c, in_ready);
      end
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_a) begin
        failures++;
        $display("FAIL bp_hold[%0d] got valid=%b data=%h want valid=1 data=%h",
                 c, out_valid, out_data, exp_a);
      end
      if (c < 2) tick();
    end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release_ready got=%b want=1", in_ready);
    end
    tick();
    drive(1'b0, '0, '0, OP_SLL);
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_b) begin
      failures++;
      $display("FAIL bp_second got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, exp_b);
    end
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_data !== exp_c) begin
      failures++;
      $display("FAIL bp_third got valid=%b data=%h want valid=1 data=%h", out_valid, out_data, exp_c);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_no_dup got=%b want=0", out_valid);
    end
  endtask

  task automatic test_mid_reset();
    out_ready = 1'b1;
    drive(1'b1, 64'hFFFF_0000_0000_0000, 6'd16, OP_SRL);
    tick();
    drive(1'b1, 64'h0000_0000_0000_FFFF, 6'd16, OP_SLL);
    tick();
    checks++;
    if (out_valid !== 1'b1 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL rst_inflight got valid=%b ready=%b want valid=1 ready=1", out_valid, in_ready);
    end
    // Reset and a valid handshake on the same edge: reset must win.
    rst = 1'b1;
    drive(1'b1, 64'h1234_5678_9ABC_DEF0, 6'd0, OP_ROR);
    tick();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("FAIL rst_flush got=%b want=0", out_valid);
    end
    rst = 1'b0;
    drive(1'b0, '0, '0, OP_SLL);
    for (int c = 0; c < 3; c++) begin
      tick();
      checks++;
      if (out_valid !== 1'b0) begin
        failures++;
        $display("FAIL rst_stale[%0d] got valid=%b data=%h want valid=0", c, out_valid, out_data);
      end
    end
    test_single("rst_fresh", 64'h0000_0000_0000_00F0, 6'd4, OP_SRL, 64'h0000_0000_0000_000F);
  endtask

  initial begin
    test_reset();
    test_modes();
    test_back_to_back();
    test_backpressure();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipelined_barrel_shifter.md
# pipelined_barrel_shifter

Parametrised, pipelined, multi-mode barrel shifter for the ALU datapath. It generalises the fixed 64-bit combinational arithmetic-right shifter to any power-of-two width and supports four modes: logical left, logical right, arithmetic right and rotate right. It has a configurable number of register stages and valid/ready handshakes on both sides, so it can sit between the operand-read and writeback stages without closing a full log-shifter in one cycle.

## Interface
Parameters:
- `WIDTH`, default 64: data width. Must be a power of two, ≥ 8.
- `STAGES`, default 2: number of pipeline register stages. Range 1..`SHAMT_W`.
- `SHAMT_W`: localparam, `$clog2(WIDTH)`. Not user-settable.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  rising-edge clock
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream presents an operation
- `in_ready`  out  1  block accepts the operation this cycle
- `in_data`  in  `WIDTH`  operand
- `in_shamt`  in  `SHAMT_W`  shift amount; values ≥ `WIDTH` are unrepresentable, so there is no masking logic
- `in_op`  in  2  mode: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- `out_valid`  out  1  result available
- `out_ready`  in  1  downstream consumes the result
- `out_data`  out  `WIDTH`  shifted result

## Operation
- Log-shifter with `SHAMT_W` mux levels. Level i shifts by 2^i when `shamt[i]` = 1; levels run LSB first.
- Levels are split across `STAGES` register boundaries. Stage k gets `ceil(SHAMT_W/STAGES)` levels, and the last stage takes the remainder.
- SLL fills with 0.
- SRL fills with 0.
- SRA fills with `in_data[WIDTH-1]`.
  - The fill bit is captured at acceptance and carried down the pipeline.
  - It is not re-derived from intermediate data.
- ROR wraps the bits shifted out into the MSBs.
- Each stage register carries:
  - a valid bit
  - partial data
  - the remaining `shamt` bits
  - `op`
  - the fill bit
- `shamt` = 0 returns `in_data` unchanged in every mode.
- Transfer happens when `valid && ready` on the same edge. No combinational path from `in_*` to `out_*`.
- Stage k advances when it is empty, or when its downstream stage advances or is consumed this cycle.
- `in_ready` = stage 0 empty, or stage 0 advances this cycle. This gives a combinational ready chain from `out_ready` to `in_ready`, which is accepted.
- Ordering: results leave in acceptance order. No drops, no duplicates.

## Timing
- Reset values: every valid bit 0, `out_valid` 0, `out_data` 0, `in_ready` 1 in the cycle after reset deasserts.
- Latency: `STAGES` cycles from the accept edge to `out_valid` high, assuming no backpressure.
- Throughput: 1 op/cycle while `out_ready` = 1.
- Backpressure:
  - While `out_valid && !out_ready`, `out_data` is held stable.
  - Upstream stages fill in turn.
  - Once all `STAGES` registers are full, `in_ready` = 0 in that same cycle.
- Simultaneous consume and accept on a full pipeline: allowed. Throughput is unchanged and no bubble is inserted.
- Reset mid-operation: every in-flight op is discarded. `out_valid` = 0 on the cycle following the reset edge, and no stale result ever appears.
- `rst` has priority over any handshake on the same edge.

## Structure
- Package `shifter_pkg` holds:
  - `typedef enum logic [1:0] shift_op_e` with values `SH_SLL`, `SH_SRL`, `SH_SRA`, `SH_ROR`
  - a function computing the per-stage level count from `WIDTH`/`STAGES`
- Sub-module `barrel_shift_stage`, instantiated `STAGES` times with generate:
  - parameters: `WIDTH`, `FIRST_LEVEL`, `NUM_LEVELS`
  - contents: the combinational mux levels for its range plus the pipeline register and valid/advance logic
- Top level holds:
  - the ready chain
  - the output mapping
  - a parameter-legality assertion (power-of-two `WIDTH`, `STAGES` range)

## Test plan
Configuration: `WIDTH`=64, `STAGES`=2, `out_ready`=1 unless stated.
- SRA, `in_data`=0x8000_0000_0000_0000, shamt 4 → `out_data`=0xF800_0000_0000_0000 exactly 2 cycles after accept. Same operand with shamt 63 → 0xFFFF_FFFF_FFFF_FFFF. Same operand with shamt 0 → unchanged.
- SRL, 0x8000_0000_0000_0000, shamt 13 → 0x0004_0000_0000_0000. SLL, 0xA0A0_A0A0_A0A0_A0A0, shamt 4 → 0x0A0A_0A0A_0A0A_0A00.
- ROR, 0x0000_0000_0000_0001, shamt 1 → 0x8000_0000_0000_0000. ROR, 0x0123_4567_89AB_CDEF, shamt 32 → 0x89AB_CDEF_0123_4567.
- Back-to-back: 4 ops issued on consecutive cycles → 4 results on consecutive cycles, in order, starting at cycle 2.
- Backpressure: `out_ready`=0 for 4 cycles while issuing 3 ops:
  - `in_ready` drops once 2 are held
  - `out_data` stays stable
  - after release, all 3 results arrive in order with no loss or duplication
- Reset with 2 ops in flight → `out_valid`=0 the next cycle, no stale result afterwards, and a fresh op completes with 2-cycle latency.
